// File: rtl/act_skew_feeder.sv
// Activation FIFO feeding a row-skewed register triangle into the weight-stationary PE array.
// Optional FEEDER_PERF_CNT_EN adds issued-vector and bubble counters.
module act_skew_feeder #(
  parameter int unsigned WORDWIDTH = 8,
  parameter int unsigned ROWS      = 4,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORDWIDTH*ROWS-1:0] in_data,
  input  logic                      in_last,
  output logic [WORDWIDTH*ROWS-1:0] a_out,
  output logic [ROWS-1:0]           enable_out,
  output logic                      busy,
`ifdef FEEDER_PERF_CNT_EN
  output logic [31:0]               perf_issued,
  output logic [31:0]               perf_bubbles,
`endif
  output logic                      done
);

  localparam logic MODE_PS = 1'b1;
  localparam int unsigned VW = WORDWIDTH * ROWS;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [VW:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push, pop, ps;
  logic [VW:0]   head;
  logic [VW-1:0] iss_data;
  logic          iss_last;
  logic [ROWS-1:0] lst_q;
  logic [ROWS-1:0] row_busy;

  assign ps       = (mode == MODE_PS);
  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = ps && (count_q != '0);
  assign head     = mem_q[rd_ptr_q];
  assign iss_data = pop ? head[VW-1:0] : '0;
  assign iss_last = pop && head[VW];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_last, in_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Row r is a chain of r+1 stages; stage 0 of every row loads from the same issue slot.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [r:0]           vld_q, v_in;
    logic [WORDWIDTH-1:0] dat_q [r+1];
    logic [WORDWIDTH-1:0] d_in  [r+1];

    for (genvar k = 0; k <= r; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign v_in[0] = pop;
        assign d_in[0] = iss_data[r*WORDWIDTH +: WORDWIDTH];
      end else begin : g_link
        assign v_in[k] = vld_q[k-1];
        assign d_in[k] = dat_q[k-1];
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld_q <= '0;
        dat_q <= '{default: '0};
      end else if (!ps) begin
        vld_q <= '0;
        dat_q <= '{default: '0};
      end else begin
        vld_q <= v_in;
        dat_q <= d_in;
      end
    end

    assign a_out[r*WORDWIDTH +: WORDWIDTH] = dat_q[r];
    assign enable_out[r] = vld_q[r];
    assign row_busy[r]   = |vld_q;
  end

  // The last-of-tile tag only matters on the deepest row, so it rides a single chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  lst_q <= '0;
    else if (!ps)  lst_q <= '0;
    else if (ROWS == 1) lst_q <= ROWS'(iss_last);
    else           lst_q <= {lst_q[ROWS-2:0], iss_last};
  end

  assign done = enable_out[ROWS-1] && lst_q[ROWS-1];
  assign busy = (count_q != '0) || (|row_busy);

`ifdef FEEDER_PERF_CNT_EN
  logic [31:0] issued_q, bubbles_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issued_q  <= '0;
      bubbles_q <= '0;
    end else begin
      if (pop)                       issued_q  <= issued_q + 32'd1;
      if (ps && (count_q == '0))     bubbles_q <= bubbles_q + 32'd1;
    end
  end

  assign perf_issued  = issued_q;
  assign perf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_act_skew_feeder.sv
// Scoreboarded bench for act_skew_feeder: per-row expected-word queues filled on accept, drained on enable_out.
module tb_act_skew_feeder;
  localparam int W = 8;
  localparam int R = 4;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           mode;
  logic           in_valid;
  logic           in_ready;
  logic [W*R-1:0] in_data;
  logic           in_last;
  logic [W*R-1:0] a_out;
  logic [R-1:0]   enable_out;
  logic           busy;
  logic           done;
`ifdef FEEDER_PERF_CNT_EN
  logic [31:0]    perf_issued;
  logic [31:0]    perf_bubbles;
`endif

  int           tests = 0;
  int           fails = 0;
  logic [W:0]   rowq [R][$];
  int           mcount = 0;
  logic [R-1:0] hist = '0;
  bit           sb_on = 1'b0;

  act_skew_feeder #(.WORDWIDTH(W), .ROWS(R), .DEPTH(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .a_out      (a_out),
    .enable_out (enable_out),
    .busy       (busy),
`ifdef FEEDER_PERF_CNT_EN
    .perf_issued  (perf_issued),
    .perf_bubbles (perf_bubbles),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;

  // Scoreboard: every enabled row must match the oldest outstanding word for that row.
  always @(negedge clk) begin
    if (sb_on) begin
      for (int r = 0; r < R; r++) begin
        logic [W:0] e;
        tests++;
        if (enable_out[r]) begin
          if (rowq[r].size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected row%0d: got enable with data %02h, expected no enable", r, a_out[r*W +: W]);
          end else begin
            e = rowq[r].pop_front();
            if (a_out[r*W +: W] !== e[W-1:0] || (r == R-1 && done !== e[W])) begin
              fails++;
              $display("FAIL sb_data row%0d: got data %02h done %b, expected data %02h done %b",
                       r, a_out[r*W +: W], done, e[W-1:0], (r == R-1) ? e[W] : done);
            end
          end
        end else if (a_out[r*W +: W] !== '0 || (r == R-1 && done !== 1'b0)) begin
          fails++;
          $display("FAIL sb_idle row%0d: got data %02h done %b, expected 00 and done 0", r, a_out[r*W +: W], done);
        end
      end
    end
  end

  task automatic model_reset();
    for (int r = 0; r < R; r++) rowq[r].delete();
    mcount = 0;
    hist   = '0;
  endtask

  // Drive one cycle from negedge+1 and update the reference model for the coming edge.
  task automatic step(input logic v, input logic [W*R-1:0] d, input logic l, input logic m);
    bit acc, iss;
    in_valid = v; in_data = d; in_last = l; mode = m;
    acc = v && (mcount < D);
    iss = m && (mcount > 0);
    if (!m) begin
      for (int r = 1; r < R; r++) begin
        int n = 0;
        for (int k = 0; k < r; k++) n += int'(hist[k]);
        repeat (n) if (rowq[r].size() > 0) void'(rowq[r].pop_front());
      end
      hist = '0;
    end else begin
      hist = {hist[R-2:0], iss};
    end
    if (acc) for (int r = 0; r < R; r++) rowq[r].push_back({l, d[r*W +: W]});
    mcount = mcount + int'(acc) - int'(iss);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if (a_out !== '0 || enable_out !== '0 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: got a_out %h en %b done %b busy %b rdy %b, expected 0 0 0 0 1",
               a_out, enable_out, done, busy, in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_single();
    logic [R-1:0] exp_en;
    step(1'b1, 32'h04030201, 1'b1, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      exp_en = (k <= R) ? R'(1 << (k - 1)) : '0;
      tests++;
      if (enable_out !== exp_en || done !== (k == R)) begin
        fails++;
        $display("FAIL single_timing edge%0d: got en %b done %b, expected en %b done %b", k, enable_out, done, exp_en, (k == R));
      end
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL single_busy: got %b, expected 0", busy);
    end
  endtask

  task automatic test_fill();
    int en0 = 0;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (in_ready !== (i < D)) begin
        fails++;
        $display("FAIL fill_ready offer%0d: got %b, expected %b", i, in_ready, (i < D));
      end
      step(1'b1, {4{8'(8'h10 + i)}}, (i == D - 1), 1'b0);
      tests++;
      if (enable_out !== '0) begin
        fails++;
        $display("FAIL fill_wl_enable offer%0d: got %b, expected 0000", i, enable_out);
      end
    end
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL fill_full: got in_ready %b, expected 0", in_ready);
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      if (enable_out[0]) en0++;
      if (k == 0) begin
        tests++;
        if (in_ready !== 1'b1) begin
          fails++;
          $display("FAIL fill_ready_after_pop: got %b, expected 1", in_ready);
        end
      end
      if (k < D) begin
        tests++;
        if (enable_out[0] !== 1'b1) begin
          fails++;
          $display("FAIL fill_consecutive edge%0d: got en0 %b, expected 1", k, enable_out[0]);
        end
      end
    end
    tests++;
    if (en0 !== D || busy !== 1'b0) begin
      fails++;
      $display("FAIL fill_drain: got %0d enables busy %b, expected %0d busy 0", en0, busy, D);
    end
  endtask

  task automatic test_stream();
`ifdef FEEDER_PERF_CNT_EN
    logic [31:0] b0 = '0;
`endif
    for (int k = 0; k < 8; k++) begin
      step(1'b1, W*R'($urandom), (k == 7), 1'b1);
`ifdef FEEDER_PERF_CNT_EN
      if (k == 0) b0 = perf_bubbles;
`endif
      if (k > 0) begin
        tests++;
        if (enable_out[0] !== 1'b1 || in_ready !== 1'b1) begin
          fails++;
          $display("FAIL stream edge%0d: got en0 %b rdy %b, expected 1 1", k, enable_out[0], in_ready);
        end
      end
    end
`ifdef FEEDER_PERF_CNT_EN
    tests++;
    if (perf_bubbles !== b0) begin
      fails++;
      $display("FAIL stream_bubbles: got %0d, expected %0d", perf_bubbles, b0);
    end
`endif
    for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_gap();
    logic [5:0] en0;
    logic [5:0] exp_en0;
`ifdef FEEDER_PERF_CNT_EN
    logic [31:0] b1 = '0;
`endif
    exp_en0 = 6'b010010;
    for (int k = 0; k < 6; k++) begin
      step((k == 0 || k == 3), (k == 0) ? 32'hA1B2C3D4 : 32'h5E6F7081, (k == 3), 1'b1);
      en0[k] = enable_out[0];
`ifdef FEEDER_PERF_CNT_EN
      if (k == 1) b1 = perf_bubbles;
      if (k == 4) begin
        tests++;
        if (perf_bubbles - b1 !== 32'd2) begin
          fails++;
          $display("FAIL gap_bubbles: got %0d, expected 2", perf_bubbles - b1);
        end
      end
`endif
    end
    tests++;
    if (en0 !== exp_en0) begin
      fails++;
      $display("FAIL gap_pattern: got en0 history %b, expected %b", en0, exp_en0);
    end
    for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_flip();
    for (int k = 0; k < 4; k++) step(1'b1, {4{8'(8'hC0 + k)}}, (k == 0), 1'b1);
    for (int k = 0; k < 2; k++) begin
      step((k == 0), 32'hEEEEEEEE, 1'b1, 1'b0);
      tests++;
      if (enable_out !== '0 || done !== 1'b0 || a_out !== '0) begin
        fails++;
        $display("FAIL flip_clear wl%0d: got en %b done %b a_out %h, expected 0 0 0", k, enable_out, done, a_out);
      end
    end
    for (int k = 0; k < 8; k++) step(1'b0, '0, 1'b0, 1'b1);
    for (int r = 0; r < R; r++) begin
      tests++;
      if (rowq[r].size() != 0) begin
        fails++;
        $display("FAIL flip_resume row%0d: got %0d words outstanding, expected 0", r, rowq[r].size());
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) step(1'b1, {4{8'(8'h70 + k)}}, 1'b1, 1'b1);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    model_reset();
    #1;
    tests++;
    if (a_out !== '0 || enable_out !== '0 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid: got a_out %h en %b done %b busy %b rdy %b, expected 0 0 0 0 1",
               a_out, enable_out, done, busy, in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) step(1'b0, '0, 1'b0, 1'b1);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_busy: got %b, expected 0", busy);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    mode     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    test_reset();
    sb_on = 1'b1;
    test_single();
    test_fill();
    test_stream();
    test_gap();
    test_flip();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
